// File: rtl/eco32_core_mpu_pkg.sv
// Shared definitions for the MPU condition-flags trace path.
//  - FLAGS_W      : width of the flags snapshot {f[9:7], f[3:0]}
//  - LOST_CNT_W   : width of the saturating dropped-update counter
//  - ent_meta_t   : upper fields of a trace entry; the timestamp sits below it,
//                   giving entry layout {lost, th, flags, ts}
//  - sat_inc()    : saturating increment for the lost counter
package eco32_core_mpu_pkg;

  localparam int FLAGS_W    = 7;
  localparam int LOST_CNT_W = 8;
  localparam logic [LOST_CNT_W-1:0] LOST_CNT_MAX = '1;

  typedef struct packed {
    logic               lost;   // at least one update was dropped before this one
    logic               th;     // thread phase at capture
    logic [FLAGS_W-1:0] flags;  // flags snapshot
  } ent_meta_t;

  localparam int ENT_META_W = $bits(ent_meta_t);

  function automatic logic [LOST_CNT_W-1:0] sat_inc(input logic [LOST_CNT_W-1:0] v);
    return (v == LOST_CNT_MAX) ? v : v + LOST_CNT_W'(1);
  endfunction

endpackage

// File: rtl/eco32_core_mpu_trace_fifo.sv
// Synchronous FIFO with a registered head for the trace path.
//  clk, rst  : clock, synchronous active-high reset (discards contents)
//  i_push    : write i_data this cycle (caller guarantees space, a same-cycle
//              pop counts as space)
//  i_data    : entry to write
//  i_ack     : consumer accepts the head when o_stb=1; ignored otherwise
//  o_stb     : head valid (registered)
//  o_data    : head entry (registered, stable while o_stb & !i_ack)
//  o_level   : number of entries held, including the head
module eco32_core_mpu_trace_fifo #(
  parameter int W   = 25,
  parameter int LOG = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_ack,
  output logic         o_stb,
  output logic [W-1:0] o_data,
  output logic [LOG:0] o_level
);

  localparam int DEPTH = 1 << LOG;
  localparam int LW    = LOG + 1;

  logic [W-1:0]   mem [DEPTH];
  logic [LOG-1:0] wr_ptr;
  logic [LOG-1:0] rd_ptr;

  logic           pop;
  logic [LOG-1:0] rd_ptr_nxt;
  logic [LOG:0]   level_nxt;
  logic [W-1:0]   head_nxt;

  // NOTE: every signal in this block is assigned on every path, so no latch is inferred.
  always_comb begin
    pop        = o_stb & i_ack;
    rd_ptr_nxt = rd_ptr + LOG'(pop);
    level_nxt  = o_level + LW'(i_push) - LW'(pop);
    // The slot being written becomes the head only when the FIFO is
    // otherwise empty after this cycle; forward it into the head register.
    head_nxt   = (i_push && (wr_ptr == rd_ptr_nxt)) ? i_data : mem[rd_ptr_nxt];
  end

  // NOTE: storage is not reset; the pointers and level define which slots are valid.
  always_ff @(posedge clk) begin
    if (i_push) begin
      mem[wr_ptr] <= i_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_level <= '0;
      o_stb   <= 1'b0;
      o_data  <= '0;
    end else begin
      if (i_push) begin
        wr_ptr <= wr_ptr + LOG'(1);
      end
      rd_ptr  <= rd_ptr_nxt;
      o_level <= level_nxt;
      o_stb   <= (level_nxt != '0);
      if (level_nxt != '0) begin
        o_data <= head_nxt;
      end
    end
  end

endmodule

// File: rtl/eco32_core_mpu_cfr_trace.sv
// Debug trace capture for the MPU condition-flags register.
// Tags each flags update with thread phase and a free-running timestamp,
// optionally de-duplicates per thread, and queues it for the trace bus.
//  clk, rst     : clock, synchronous active-high reset
//  i_en         : trace enable (0 = no capture; queued entries still drain)
//  i_dedup      : drop an update equal to the last flags seen on the same thread
//  i_clr        : clear o_lost_cnt, o_ovf and the pending-lost marker
//  i_stb        : flag-change strobe from the flags register
//  i_flags      : flags snapshot {f[9:7], f[3:0]}
//  o_stb/i_ack  : FIFO head valid / consumer accept
//  o_data       : head entry {lost, th, flags, ts}
//  o_level      : entries held
//  o_ovf        : sticky drop indicator
//  o_lost_cnt   : dropped updates, saturating
module eco32_core_mpu_cfr_trace
  import eco32_core_mpu_pkg::*;
#(
  parameter int TS_W     = 16,
  parameter int FIFO_LOG = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_en,
  input  logic                       i_dedup,
  input  logic                       i_clr,
  input  logic                       i_stb,
  input  logic [FLAGS_W-1:0]         i_flags,
  output logic                       o_stb,
  input  logic                       i_ack,
  output logic [TS_W+ENT_META_W-1:0] o_data,
  output logic [FIFO_LOG:0]          o_level,
  output logic                       o_ovf,
  output logic [LOST_CNT_W-1:0]      o_lost_cnt
);

  localparam int ENT_W = TS_W + ENT_META_W;

  logic [TS_W-1:0]    ts;
  logic               th;
  logic               pend;
  logic [FLAGS_W-1:0] last [2];

  logic               cand;
  logic               dup;
  logic               keep;
  logic               pop;
  logic               room;
  logic               wr;
  logic               drop;
  ent_meta_t          meta;
  logic [ENT_W-1:0]   wr_data;

  always_comb begin
    cand       = i_stb & i_en;
    dup        = i_dedup & (i_flags == last[th]);
    keep       = cand & ~dup;
    pop        = o_stb & i_ack;
    // Level never exceeds the depth, so its MSB alone marks "full".
    room       = ~o_level[FIFO_LOG] | pop;
    wr         = keep & room;
    drop       = keep & ~room;
    meta.lost  = pend;
    meta.th    = th;
    meta.flags = i_flags;
    wr_data    = {meta, ts};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts         <= '0;
      th         <= 1'b0;
      pend       <= 1'b0;
      o_ovf      <= 1'b0;
      o_lost_cnt <= '0;
      last[0]    <= '0;
      last[1]    <= '0;
    end else begin
      ts <= ts + TS_W'(1);
      th <= ~th;
      // The per-thread history follows every candidate, even discarded ones.
      if (cand) begin
        last[th] <= i_flags;
      end
      // A drop in the same cycle as a clear wins: the drop is the first
      // event of the new counting window.
      if (drop) begin
        pend       <= 1'b1;
        o_ovf      <= 1'b1;
        o_lost_cnt <= i_clr ? LOST_CNT_W'(1) : sat_inc(o_lost_cnt);
      end else if (i_clr) begin
        pend       <= 1'b0;
        o_ovf      <= 1'b0;
        o_lost_cnt <= '0;
      end else if (wr) begin
        pend <= 1'b0;
      end
    end
  end

  eco32_core_mpu_trace_fifo #(
    .W   (ENT_W),
    .LOG (FIFO_LOG)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (wr),
    .i_data  (wr_data),
    .i_ack   (i_ack),
    .o_stb   (o_stb),
    .o_data  (o_data),
    .o_level (o_level)
  );

endmodule

// File: tb/tb_eco32_core_mpu_cfr_trace.sv
// Self-checking bench for eco32_core_mpu_cfr_trace. A behavioural model
// (entry queue, per-thread history, drop bookkeeping) is stepped on every
// clock edge and compared with the DUT outputs 1 ns after the edge.
module tb_eco32_core_mpu_cfr_trace;

  localparam int TS_W  = 16;
  localparam int DEPTH = 16;
  localparam int ENT_W = TS_W + 9;

  logic             clk;
  logic             rst;
  logic             i_en;
  logic             i_dedup;
  logic             i_clr;
  logic             i_stb;
  logic [6:0]       i_flags;
  logic             o_stb;
  logic             i_ack;
  logic [ENT_W-1:0] o_data;
  logic [4:0]       o_level;
  logic             o_ovf;
  logic [7:0]       o_lost_cnt;

  int checks;
  int errors;

  // reference model state
  logic [ENT_W-1:0] m_q[$];
  bit               m_pend;
  bit               m_ovf;
  int               m_cnt;
  logic [6:0]       m_last [2];
  int unsigned      m_cyc;

  eco32_core_mpu_cfr_trace #(
    .TS_W     (TS_W),
    .FIFO_LOG (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_en       (i_en),
    .i_dedup    (i_dedup),
    .i_clr      (i_clr),
    .i_stb      (i_stb),
    .i_flags    (i_flags),
    .o_stb      (o_stb),
    .i_ack      (i_ack),
    .o_data     (o_data),
    .o_level    (o_level),
    .o_ovf      (o_ovf),
    .o_lost_cnt (o_lost_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge of the model, using the inputs the DUT sees at that edge.
  task automatic model_step();
    bit         th;
    logic [15:0] ts;
    bit         pop, cand, keep, roomy;
    if (rst) begin
      m_q.delete();
      m_pend = 0;
      m_ovf  = 0;
      m_cnt  = 0;
      m_last = '{default: '0};
      m_cyc  = 0;
    end else begin
      th    = (m_cyc % 2) == 1;
      ts    = 16'(m_cyc % 65536);
      pop   = (m_q.size() != 0) && i_ack;
      cand  = i_stb && i_en;
      keep  = cand && !(i_dedup && (i_flags == m_last[th]));
      roomy = (m_q.size() < DEPTH) || pop;
      if (pop) void'(m_q.pop_front());
      if (keep && roomy) begin
        m_q.push_back({m_pend, th, i_flags, ts});
        m_pend = 0;
      end
      if (i_clr) begin
        m_cnt  = 0;
        m_ovf  = 0;
        m_pend = 0;
      end
      if (keep && !roomy) begin
        m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
        m_ovf  = 1;
        m_pend = 1;
      end
      if (cand) m_last[th] = i_flags;
      m_cyc++;
    end
  endtask

  task automatic compare_all();
    check("stb", 32'(o_stb), 32'(m_q.size() != 0));
    check("level", 32'(o_level), 32'(m_q.size()));
    check("ovf", 32'(o_ovf), 32'(m_ovf));
    check("lost_cnt", 32'(o_lost_cnt), 32'(m_cnt));
    if (m_q.size() != 0) check("data", 32'(o_data), 32'(m_q[0]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    i_en    = 1'b0;
    i_dedup = 1'b0;
    i_clr   = 1'b0;
    i_stb   = 1'b0;
    i_flags = '0;
    i_ack   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_data", 32'(o_data), 32'd0);
    check("rst_stb", 32'(o_stb), 32'd0);
  endtask

  initial begin
    int          stb_seen;
    int          ack_pct;
    logic [24:0] exp_ent;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    idle_inputs();
    @(negedge clk);

    // --- reset then two captures at cycles 3 and 4, ack held high ---
    do_reset();
    i_en  = 1'b1;
    i_ack = 1'b1;
    tick(); tick(); tick();                // cycles 0..2
    i_stb = 1'b1; i_flags = 7'h15;
    tick();                                // cycle 3
    exp_ent = {1'b0, 1'b1, 7'h15, 16'd3};
    check("t1_e0", 32'(o_data), 32'(exp_ent));
    i_flags = 7'h2A;
    tick();                                // cycle 4
    exp_ent = {1'b0, 1'b0, 7'h2A, 16'd4};
    check("t1_e1", 32'(o_data), 32'(exp_ent));
    i_stb = 1'b0;
    tick();
    check("t1_empty", 32'(o_stb), 32'd0);

    // --- dedup on thread 0 ---
    do_reset();
    i_en = 1'b1; i_dedup = 1'b1; i_ack = 1'b1;
    stb_seen = 0;
    for (int i = 0; i < 9; i++) begin
      i_stb   = ((i % 2) == 0) && (i <= 6);
      i_flags = (i < 6) ? 7'h11 : 7'h12;
      tick();
      if (o_stb) stb_seen++;
    end
    check("dedup_entries", 32'(stb_seen), 32'd2);
    check("dedup_cnt", 32'(o_lost_cnt), 32'd0);

    // --- overflow: 20 strobes with no ack, then drain in order ---
    do_reset();
    i_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      i_stb = 1'b1; i_flags = 7'(i + 1);
      tick();
    end
    check("ovf_level", 32'(o_level), 32'd16);
    check("ovf_cnt", 32'(o_lost_cnt), 32'd4);
    check("ovf_flag", 32'(o_ovf), 32'd1);
    i_stb = 1'b0; i_ack = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("ovf_order", 32'(o_data[22:16]), 32'(i + 1));
      tick();
    end
    check("ovf_drained", 32'(o_level), 32'd0);
    i_stb = 1'b1; i_flags = 7'h55;
    tick();
    check("lost_bit_set", 32'(o_data[24]), 32'd1);
    i_flags = 7'h56;
    tick();
    check("lost_bit_clr", 32'(o_data[24]), 32'd0);
    i_stb = 1'b0;
    tick();

    // --- full FIFO with simultaneous push and pop ---
    do_reset();
    i_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      i_stb = 1'b1; i_flags = 7'(i);
      tick();
    end
    check("full_level", 32'(o_level), 32'd16);
    i_flags = 7'h3C; i_ack = 1'b1;
    tick();
    check("full_pushpop_level", 32'(o_level), 32'd16);
    check("full_pushpop_cnt", 32'(o_lost_cnt), 32'd0);

    // --- saturation and clear-vs-drop priority ---
    i_ack = 1'b0;
    for (int i = 0; i < 300; i++) begin
      i_flags = 7'(i);
      tick();
    end
    check("sat_cnt", 32'(o_lost_cnt), 32'd255);
    i_clr = 1'b1;
    tick();
    check("clr_drop_cnt", 32'(o_lost_cnt), 32'd1);
    check("clr_drop_ovf", 32'(o_ovf), 32'd1);
    i_stb = 1'b0;
    tick();
    check("clr_cnt", 32'(o_lost_cnt), 32'd0);
    check("clr_ovf", 32'(o_ovf), 32'd0);
    i_clr = 1'b0;

    // --- randomized traffic against the model ---
    do_reset();
    for (int seg = 0; seg < 6; seg++) begin
      ack_pct = (seg % 3 == 0) ? 10 : ((seg % 3 == 1) ? 50 : 90);
      for (int i = 0; i < 500; i++) begin
        i_en    = ($urandom_range(0, 7) != 0);
        i_dedup = ($urandom_range(0, 1) != 0);
        i_clr   = ($urandom_range(0, 63) == 0);
        i_stb   = ($urandom_range(0, 1) != 0);
        i_flags = 7'($urandom_range(0, 3));
        i_ack   = ($urandom_range(0, 99) < ack_pct);
        tick();
      end
    end

    // --- timestamp wrap, then reset mid-drain ---
    do_reset();
    i_en = 1'b1; i_ack = 1'b1;
    for (int i = 0; i < 65535; i++) tick();   // cycles 0..65534
    i_stb = 1'b1; i_flags = 7'h7F;
    tick();                                  // cycle 65535
    check("wrap_ts_max", 32'(o_data[15:0]), 32'hFFFF);
    check("wrap_th_max", 32'(o_data[23]), 32'd1);
    i_flags = 7'h01;
    tick();                                  // cycle 65536
    check("wrap_ts_zero", 32'(o_data[15:0]), 32'd0);
    check("wrap_th_zero", 32'(o_data[23]), 32'd0);
    i_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      i_flags = 7'(i + 2);
      tick();
    end
    check("drain_level", 32'(o_level), 32'd5);
    i_stb = 1'b0; i_ack = 1'b1; rst = 1'b1;
    tick();
    check("midrst_stb", 32'(o_stb), 32'd0);
    check("midrst_level", 32'(o_level), 32'd0);
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
